// File: rtl/fft_stage_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_stage_ctrl
// Purpose  : Per-stage sequencer for a P-parallel N-point FFT pipeline.
//            Tracks the beat position inside each frame from a valid/ready
//            sample stream. For every accepted beat it produces a registered
//            control word holding the twiddle ROM address, the butterfly/pass
//            select, the beat index and the frame markers. The output is a
//            single registered slot, so the latency is one cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/in_sop - upstream beat and start-of-frame flag
//            in_ready        - beat accepted (combinational from slot state)
//            out_ready       - downstream accepts the control word
//            out_valid/out_sop/out_eop/coeff_addr/bf_sel/beat_idx
//                            - registered control word
//            err_resync      - pulse: sop arrived in the middle of a frame
//            drop_pulse      - pulse: non-sop beat discarded while idle
//            busy            - a frame is in progress
//            frame_cnt       - completed-frame counter (optional, see below)
// Options  : FFT_STAGE_CTRL_FRAME_CNT_EN - when defined, adds frame_cnt[15:0],
//            counting accepted eop words (wraps 0xFFFF -> 0).
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_ctrl #(
  parameter int N     = 128,
  parameter int P     = 4,
  parameter int STAGE = 0,
  parameter int AW    = $clog2(N),
  parameter int BW    = $clog2(N/P)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sop,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [AW-1:0] coeff_addr,
  output logic          bf_sel,
  output logic [BW-1:0] beat_idx,
  output logic          err_resync,
  output logic          drop_pulse,
  output logic          busy
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int            c_BEATS  = N / P;
  localparam int            c_GRAW   = (N >> STAGE) / P;
  // Butterfly group length in beats; late stages pair lanes inside a beat.
  localparam int            c_G      = (c_GRAW < 1) ? 1 : c_GRAW;
  localparam logic [BW-1:0] c_LAST   = BW'(c_BEATS - 1);
  localparam logic [BW-1:0] c_GMASK  = BW'(c_G - 1);
  localparam bit            c_SINGLE = (c_BEATS == 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_b;
  logic            r_valid;
  logic            r_sop;
  logic            r_eop;
  logic [AW-1:0]   r_coeff;
  logic            r_bf;
  logic [BW-1:0]   r_beat;
  logic            r_err;
  logic            r_drop;

  logic            w_xfer;
  logic [BW-1:0]   w_b_inc;
  logic [BW-1:0]   w_b_next;
  logic [BW-1:0]   w_r;
  logic [AW-1:0]   w_coeff;
  logic            w_bf;
  logic            w_eop_next;

  // A new word may enter whenever the slot is empty or is being drained.
  assign in_ready = !r_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  assign w_b_inc    = (r_b == c_LAST) ? '0 : r_b + BW'(1);
  assign w_b_next   = in_sop ? '0 : w_b_inc;
  assign w_eop_next = (w_b_next == c_LAST);

  // G is a power of two, so b mod G is a mask.
  assign w_r     = w_b_next & c_GMASK;
  assign w_coeff = AW'(w_r) << STAGE;

  generate
    if (c_G >= 2) begin : g_bf_split
      localparam logic [BW-1:0] c_GHALF = BW'(c_G / 2);
      assign w_bf = (w_r >= c_GHALF);
    end else begin : g_bf_always
      assign w_bf = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_coeff <= '0;
      r_bf    <= 1'b0;
      r_beat  <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;
      if (w_xfer) begin
        if (in_sop || (r_state == S_RUN)) begin
          r_b     <= w_b_next;
          r_valid <= 1'b1;
          r_sop   <= in_sop;
          r_eop   <= w_eop_next;
          r_coeff <= w_coeff;
          r_bf    <= w_bf;
          r_beat  <= w_b_next;
          r_err   <= in_sop && (r_state == S_RUN);
          // A one-beat frame opens and closes on the same word.
          if (w_eop_next || (in_sop && c_SINGLE)) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end else begin
          // Idle and no sop: the beat is swallowed, the slot drains.
          r_valid <= 1'b0;
          r_drop  <= 1'b1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_sop    = r_sop;
  assign out_eop    = r_eop;
  assign coeff_addr = r_coeff;
  assign bf_sel     = r_bf;
  assign beat_idx   = r_beat;
  assign err_resync = r_err;
  assign drop_pulse = r_drop;
  assign busy       = (r_state == S_RUN);

`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Only frames that reach eop are counted; resync-aborted ones never do.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (r_valid && out_ready && r_eop) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_stage_ctrl
// Purpose  : Self-checking bench for fft_stage_ctrl. Two instances (stage 0
//            and stage 3) share one stimulus stream; a frame-level model
//            queues expected words and a monitor compares them on the falling
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stage_ctrl;

  localparam int N     = 128;
  localparam int P     = 4;
  localparam int AW    = $clog2(N);
  localparam int BW    = $clog2(N/P);
  localparam int BEATS = N / P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sop = 1'b0;
  logic out_ready = 1'b0;

  logic          in_ready_a, out_valid_a, out_sop_a, out_eop_a, bf_sel_a;
  logic          err_a, drop_a, busy_a;
  logic [AW-1:0] coeff_a;
  logic [BW-1:0] beat_a;
  logic          in_ready_b, out_valid_b, out_sop_b, out_eop_b, bf_sel_b;
  logic          err_b, drop_b, busy_b;
  logic [AW-1:0] coeff_b;
  logic [BW-1:0] beat_b;
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0]   fc_a, fc_b;
`endif

  always #5 clk = ~clk;

  fft_stage_ctrl #(.N(N), .P(P), .STAGE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready_a), .out_ready(out_ready), .out_valid(out_valid_a),
    .out_sop(out_sop_a), .out_eop(out_eop_a), .coeff_addr(coeff_a),
    .bf_sel(bf_sel_a), .beat_idx(beat_a), .err_resync(err_a),
    .drop_pulse(drop_a), .busy(busy_a)
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  fft_stage_ctrl #(.N(N), .P(P), .STAGE(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready_b), .out_ready(out_ready), .out_valid(out_valid_b),
    .out_sop(out_sop_b), .out_eop(out_eop_b), .coeff_addr(coeff_b),
    .bf_sel(bf_sel_b), .beat_idx(beat_b), .err_resync(err_b),
    .drop_pulse(drop_b), .busy(busy_b)
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  int checks = 0;
  int failures = 0;
  int drops_seen = 0;

  typedef struct {
    int beat;
    bit sop;
    bit eop;
    bit err;
  } word_t;

  word_t       q[$];
  bit          m_in_frame = 1'b0;
  int          m_beat = 0;
  bit          m_drop_pend = 1'b0;
  logic [15:0] exp_fc = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: group length, twiddle address and butterfly select.
  function automatic int g_len(input int st);
    int g;
    g = (N >> st) / P;
    return (g < 1) ? 1 : g;
  endfunction

  function automatic logic [31:0] exp_coeff(input int beat, input int st);
    return 32'((beat % g_len(st)) << st);
  endfunction

  function automatic logic [31:0] exp_bf(input int beat, input int st);
    int g;
    g = g_len(st);
    if (g == 1) return 32'd1;
    return 32'((beat % g) >= (g / 2));
  endfunction

  // Frame-level model of one accepted beat.
  task automatic model_accept(input bit sop);
    word_t w;
    if (sop) begin
      w.err = m_in_frame;
      m_beat = 0;
      w.beat = 0;
      w.sop = 1'b1;
      w.eop = (BEATS == 1);
      m_in_frame = (BEATS != 1);
      q.push_back(w);
    end else if (m_in_frame) begin
      m_beat++;
      w.beat = m_beat;
      w.sop = 1'b0;
      w.err = 1'b0;
      w.eop = (m_beat == BEATS - 1);
      if (w.eop) m_in_frame = 1'b0;
      q.push_back(w);
    end else begin
      m_drop_pend = 1'b1;
    end
  endtask

  task automatic cycle(input bit v, input bit s, input bit ordy, output bit acc);
    in_valid = v;
    in_sop = s;
    out_ready = ordy;
    @(negedge clk);
    acc = v && (in_ready_a === 1'b1);
    @(posedge clk);
    if (acc) model_accept(s);
    #1;
  endtask

  task automatic send(input bit s, input bit ordy);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      cycle(1'b1, s, ordy, acc);
      n++;
    end
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic frame(input int len);
    send(1'b1, 1'b1);
    for (int i = 1; i < len; i++) send(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    q.delete();
    m_in_frame = 1'b0;
    m_beat = 0;
    m_drop_pend = 1'b0;
    exp_fc = 16'd0;
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_beat_idx", 32'(beat_a), 32'd0);
    chk("rst_coeff", 32'(coeff_a), 32'd0);
    chk("rst_sop_eop", 32'({out_sop_a, out_eop_a, bf_sel_a}), 32'd0);
    chk("rst_pulses", 32'({err_a, drop_a}), 32'd0);
    chk("rst_b_valid", 32'({out_valid_b, busy_b}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares the presented word against the queue head.
  initial begin : monitor
    bit fresh;
    word_t w;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        fresh = 1'b1;
      end else begin
        chk("out_valid_a", 32'(out_valid_a), 32'(q.size() != 0));
        chk("out_valid_b", 32'(out_valid_b), 32'(q.size() != 0));
        chk("in_ready", 32'({in_ready_a, in_ready_b}),
            (q.size() == 0 || out_ready) ? 32'd3 : 32'd0);
        chk("busy", 32'({busy_a, busy_b}), m_in_frame ? 32'd3 : 32'd0);
        chk("drop_pulse", 32'({drop_a, drop_b}), m_drop_pend ? 32'd3 : 32'd0);
        if (drop_a) drops_seen++;
        m_drop_pend = 1'b0;
`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
        chk("frame_cnt_a", 32'(fc_a), 32'(exp_fc));
        chk("frame_cnt_b", 32'(fc_b), 32'(exp_fc));
`endif
        if (q.size() != 0 && out_valid_a) begin
          w = q[0];
          chk("beat_idx_a", 32'(beat_a), 32'(w.beat));
          chk("beat_idx_b", 32'(beat_b), 32'(w.beat));
          chk("sop_eop_a", 32'({out_sop_a, out_eop_a}), 32'({w.sop, w.eop}));
          chk("sop_eop_b", 32'({out_sop_b, out_eop_b}), 32'({w.sop, w.eop}));
          chk("coeff_a", 32'(coeff_a), exp_coeff(w.beat, 0));
          chk("coeff_b", 32'(coeff_b), exp_coeff(w.beat, 3));
          chk("bf_sel_a", 32'(bf_sel_a), exp_bf(w.beat, 0));
          chk("bf_sel_b", 32'(bf_sel_b), exp_bf(w.beat, 3));
          chk("err_resync", 32'({err_a, err_b}), (fresh && w.err) ? 32'd3 : 32'd0);
          if (out_ready) begin
            void'(q.pop_front());
            if (w.eop) exp_fc = exp_fc + 16'd1;
            fresh = 1'b1;
          end else begin
            fresh = 1'b0;
          end
        end else begin
          chk("err_idle", 32'({err_a, err_b}), 32'd0);
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit acc;
    int d0;
    bit v, s, r;

    do_reset();

    // Back-to-back frame, no stalls.
    frame(BEATS);
    idle(3);

    // Stall for five cycles while beat 7 is held in the slot.
    send(1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) send(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, acc);
    for (int i = 8; i < BEATS; i++) send(1'b0, 1'b1);
    idle(3);

    // Resync in the middle of a frame, then a full frame.
    for (int i = 0; i <= 10; i++) send(i == 0, 1'b1);
    frame(BEATS);
    idle(3);

    // Beats before sop are dropped; reset mid-frame abandons it.
    d0 = drops_seen;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1);
    idle(2);
    chk("drop_count", 32'(drops_seen - d0), 32'd3);
    frame(21);
    do_reset();

`ifdef FFT_STAGE_CTRL_FRAME_CNT_EN
    frame(10);
    frame(BEATS);
    frame(BEATS);
    frame(BEATS);
    idle(3);
    chk("frame_cnt_three", 32'(fc_a), 32'd3);
    force dut_a.r_frame_cnt = 16'hFFFF;
    force dut_b.r_frame_cnt = 16'hFFFF;
    exp_fc = 16'hFFFF;
    #1;
    release dut_a.r_frame_cnt;
    release dut_b.r_frame_cnt;
    idle(1);
    frame(BEATS);
    idle(3);
    chk("frame_cnt_wrap", 32'(fc_a), 32'd0);
`endif

    // Randomised traffic with backpressure and occasional resyncs.
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = m_in_frame ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 7);
      cycle(v, s, r, acc);
    end
    idle(5);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
